// File: rtl/regfile_scan_ctrl_if.sv
// Register-file port bus borrowed by the scan sequencer: ownership handshake
// plus one asynchronous read port and one write port.
interface regfile_scan_ctrl_if #(
   parameter int SIZE  = 16,
   parameter int WIDTH = 32
);
   localparam int AW = $clog2(SIZE);

   logic             portReq;
   logic             portGnt;
   logic [AW-1:0]    rdAddr;
   logic [WIDTH-1:0] rdData;
   logic             wrEnable;
   logic [AW-1:0]    wrAddr;
   logic [WIDTH-1:0] wrData;

   modport master (
      output portReq, rdAddr, wrEnable, wrAddr, wrData,
      input  portGnt, rdData
   );

   modport slave (
      input  portReq, rdAddr, wrEnable, wrAddr, wrData,
      output portGnt, rdData
   );
endinterface

// File: rtl/regfile_scan_ctrl.sv
// Diagnostic scan sequencer: walks every register in ascending order, shifts each
// word out MSB-first and optionally writes the shifted-in word back (never reg 0).
module regfile_scan_ctrl #(
   parameter int SIZE  = 16,
   parameter int WIDTH = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic scanStart,
   input  logic scanWrite,
   input  logic scanAbort,
   output logic scanBusy,
   output logic scanDone,
   input  logic sEnable,
   input  logic sIn,
   output logic sOut,
   regfile_scan_ctrl_if.master rf
);
   localparam int AW = $clog2(SIZE);
   localparam int BW = $clog2(WIDTH) + 1;

   typedef enum logic [2:0] {IDLE, REQ, LOAD, SHIFT, WRITE, DONE} state_t;

   state_t           state, nxt;
   logic [AW-1:0]    addr;
   logic [WIDTH-1:0] shiftReg;
   logic [BW-1:0]    bitCnt;
   logic             writeBack;
   logic             shiftEn, lastBit, lastAddr;

   assign lastAddr = (addr == AW'(SIZE - 1));
   assign lastBit  = (bitCnt == BW'(WIDTH - 1));
   assign shiftEn  = (state == SHIFT) && rf.portGnt && sEnable && !scanAbort;

   assign sOut        = shiftReg[WIDTH-1];
   assign rf.rdAddr   = addr;
   assign rf.wrEnable = (state == WRITE) && rf.portGnt && !scanAbort;
   assign rf.wrAddr   = (state == WRITE) ? addr : '0;
   assign rf.wrData   = (state == WRITE) ? shiftReg : '0;

   // Abort outranks everything outside IDLE; every advance past REQ needs the grant.
   always_comb begin
      nxt = state;
      if (state != IDLE && scanAbort) begin
         nxt = IDLE;
      end else begin
         case (state)
            IDLE:  if (scanStart && !scanAbort) nxt = REQ;
            REQ:   if (rf.portGnt) nxt = LOAD;
            LOAD:  if (rf.portGnt) nxt = SHIFT;
            SHIFT: begin
               if (shiftEn && lastBit) begin
                  if (writeBack && addr != '0) nxt = WRITE;
                  else if (lastAddr)           nxt = DONE;
                  else                         nxt = LOAD;
               end
            end
            WRITE: if (rf.portGnt) nxt = lastAddr ? DONE : LOAD;
            DONE:  nxt = IDLE;
            default: nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         addr       <= '0;
         shiftReg   <= '0;
         bitCnt     <= '0;
         writeBack  <= 1'b0;
         scanBusy   <= 1'b0;
         scanDone   <= 1'b0;
         rf.portReq <= 1'b0;
      end else begin
         state      <= nxt;
         scanBusy   <= (nxt != IDLE);
         scanDone   <= (nxt == DONE);
         rf.portReq <= (nxt == REQ) || (nxt == LOAD) || (nxt == SHIFT) || (nxt == WRITE);
         if (state == IDLE && nxt == REQ) begin
            writeBack <= scanWrite;
            addr      <= '0;
         end
         if (state == LOAD && nxt == SHIFT) begin
            shiftReg <= rf.rdData;
            bitCnt   <= '0;
         end
         if (shiftEn) begin
            shiftReg <= {shiftReg[WIDTH-2:0], sIn};
            bitCnt   <= bitCnt + BW'(1);
         end
         if ((state == SHIFT || state == WRITE) && nxt == LOAD) begin
            addr <= addr + AW'(1);
         end
      end
   end
endmodule

// File: tb/tb_regfile_scan_ctrl.sv
// Scoreboard bench for regfile_scan_ctrl on a 4 x 8-bit register file model.
module tb_regfile_scan_ctrl;
   localparam int SIZE  = 4;
   localparam int WIDTH = 8;

   typedef enum {M_IDLE, M_REQ, M_LOAD, M_SHIFT, M_WRITE, M_DONE} mst_t;

   logic clk = 1'b0;
   logic rst, scanStart, scanWrite, scanAbort, sEnable, sIn;
   logic scanBusy, scanDone, sOut;

   regfile_scan_ctrl_if #(.SIZE(SIZE), .WIDTH(WIDTH)) rf_bus ();

   regfile_scan_ctrl #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst),
      .scanStart(scanStart), .scanWrite(scanWrite), .scanAbort(scanAbort),
      .scanBusy(scanBusy), .scanDone(scanDone),
      .sEnable(sEnable), .sIn(sIn), .sOut(sOut),
      .rf(rf_bus)
   );

   always #5 clk = ~clk;

   logic [7:0] rf_mem   [SIZE];
   logic [7:0] init_val [SIZE];
   logic [7:0] sin_word [SIZE];
   assign rf_bus.rdData = rf_mem[rf_bus.rdAddr];

   logic        exp_bits[$];
   logic [15:0] exp_wr[$];
   int total = 0, bad = 0;
   int tcount = 0, t_load, t_done;
   mst_t m_st = M_IDLE;
   int m_r = 0, m_k = 0;
   bit m_wb = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock: drive inputs, check outputs against the reference model, advance it.
   task automatic tick(input logic g, input logic en, input logic ab, input logic st, input logic wr);
      logic [7:0] wv;
      logic sh;
      @(negedge clk);
      rf_bus.portGnt = g; sEnable = en; scanAbort = ab; scanStart = st; scanWrite = wr;
      sIn = 1'b0;
      if (m_st == M_SHIFT) begin
         wv  = sin_word[m_r];
         sIn = wv[7-m_k];
      end
      #1;
      tcount++;
      chk("portReq", rf_bus.portReq, m_st inside {M_REQ, M_LOAD, M_SHIFT, M_WRITE});
      chk("scanBusy", scanBusy, m_st != M_IDLE);
      chk("scanDone", scanDone, m_st == M_DONE);
      chk("wrEnable", rf_bus.wrEnable, (m_st == M_WRITE) && g && !ab);
      if (m_st != M_IDLE) chk("rdAddr", rf_bus.rdAddr, m_r);
      if (m_st != M_WRITE) begin
         chk("wrAddrIdle", rf_bus.wrAddr, 0);
         chk("wrDataIdle", rf_bus.wrData, 0);
      end
      sh = (m_st == M_SHIFT) && g && en && !ab;
      if (m_st == M_SHIFT && exp_bits.size() > 0) begin
         if (sh) chk("sOut", sOut, exp_bits.pop_front());
         else    chk("sOutHold", sOut, exp_bits[0]);
      end
      if (rf_bus.wrEnable) begin
         chk("wrQueued", 32'(exp_wr.size() != 0), 1);
         if (exp_wr.size() != 0)
            chk("wrAddrData", {8'(rf_bus.wrAddr), rf_bus.wrData}, exp_wr.pop_front());
         rf_mem[rf_bus.wrAddr] = rf_bus.wrData;
      end
      if (m_st == M_LOAD && m_r == 0) t_load = tcount;
      if (scanDone) t_done = tcount;
      if (m_st == M_IDLE) begin
         if (st && !ab) begin m_st = M_REQ; m_wb = wr; m_r = 0; end
      end else if (ab) begin
         m_st = M_IDLE;
      end else begin
         case (m_st)
            M_REQ:  if (g) m_st = M_LOAD;
            M_LOAD: if (g) begin m_st = M_SHIFT; m_k = 0; end
            M_SHIFT: if (sh) begin
               m_k++;
               if (m_k == WIDTH) begin
                  if (m_wb && m_r != 0)   m_st = M_WRITE;
                  else if (m_r == SIZE-1) m_st = M_DONE;
                  else begin m_r++; m_st = M_LOAD; end
               end
            end
            M_WRITE: if (g) begin
               if (m_r == SIZE-1) m_st = M_DONE;
               else begin m_r++; m_st = M_LOAD; end
            end
            default: m_st = M_IDLE;
         endcase
      end
   endtask

   task automatic do_reset_mid();
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rstBusy", scanBusy, 0);
      chk("rstDone", scanDone, 0);
      chk("rstReq", rf_bus.portReq, 0);
      chk("rstWrEn", rf_bus.wrEnable, 0);
      chk("rstRdAddr", rf_bus.rdAddr, 0);
      chk("rstWrAddr", rf_bus.wrAddr, 0);
      chk("rstWrData", rf_bus.wrData, 0);
      chk("rstSOut", sOut, 0);
      m_st = M_IDLE; m_r = 0; m_k = 0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   // mode: 0 nominal, 1 grant gaps, 2 sEnable toggling, 3 abort in WRITE of reg 2, 4 reset mid-SHIFT
   task automatic run_pass(input bit wr, input int mode);
      logic [7:0] w;
      logic g, en, ab;
      int reqwait, drop;
      exp_bits.delete();
      exp_wr.delete();
      for (int r = 0; r < SIZE; r++) begin
         rf_mem[r] = init_val[r];
         w = init_val[r];
         for (int b = WIDTH-1; b >= 0; b--) exp_bits.push_back(w[b]);
         if (wr && r != 0 && !(mode == 3 && r >= 2)) exp_wr.push_back(16'({8'(r), sin_word[r]}));
      end
      t_load = -1; t_done = -1; reqwait = 0; drop = 0; en = 1'b1;
      tick(1'b1, 1'b1, 1'b0, 1'b1, wr);
      for (int i = 0; i < 600 && m_st != M_IDLE; i++) begin
         g = 1'b1; ab = 1'b0;
         en = (mode == 2) ? !en : 1'b1;
         if (mode == 1 && m_st == M_REQ && reqwait < 5) begin g = 1'b0; reqwait++; end
         if (mode == 1 && m_st == M_SHIFT && m_r == 1 && m_k == 4 && drop < 3) begin g = 1'b0; drop++; end
         if (mode == 3 && m_st == M_WRITE && m_r == 2) ab = 1'b1;
         if (mode == 4 && m_st == M_SHIFT && m_r == 1 && m_k == 3) begin
            do_reset_mid();
            return;
         end
         tick(g, en, ab, 1'b0, 1'b0);
      end
      chk("passEnds", m_st, M_IDLE);
      tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("wrLeft", exp_wr.size(), 0);
      if (mode == 3) begin
         chk("reg2Kept", rf_mem[2], 8'h3C);
         chk("abortNoDone", t_done, 32'hFFFF_FFFF);
      end else begin
         chk("bitsLeft", exp_bits.size(), 0);
         if (mode == 0) chk("duration", t_done - t_load, wr ? 39 : 36);
         if (mode == 2) chk("durToggleLonger", 32'((t_done - t_load) > 36), 1);
      end
   endtask

   initial begin
      init_val = '{8'h00, 8'hA5, 8'h3C, 8'hFF};
      sin_word = '{8'h11, 8'h22, 8'h33, 8'h44};
      rst = 1'b0; scanStart = 1'b0; scanWrite = 1'b0; scanAbort = 1'b0;
      sEnable = 1'b0; sIn = 1'b0; rf_bus.portGnt = 1'b0;
      for (int r = 0; r < SIZE; r++) rf_mem[r] = init_val[r];
      @(negedge clk);
      @(negedge clk);
      chk("resetBusy", scanBusy, 0);
      chk("resetDone", scanDone, 0);
      chk("resetReq", rf_bus.portReq, 0);
      chk("resetRdAddr", rf_bus.rdAddr, 0);
      chk("resetSOut", sOut, 0);
      rst = 1'b1;

      run_pass(1'b0, 0);
      run_pass(1'b1, 0);
      run_pass(1'b0, 1);
      run_pass(1'b0, 2);
      run_pass(1'b1, 3);
      // start together with abort in IDLE must be ignored
      tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      run_pass(1'b0, 4);
      run_pass(1'b0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/regfile_scan_ctrl.md
Name: regfile_scan_ctrl

Overview:
- Diagnostic scan sequencer for the general and segment register files.
- Borrows one read port and one write port from a register file through a request/grant handshake with the pipeline.
- Walks every register in ascending address order and shifts each word out MSB-first on a serial line.
- Optionally shifts in replacement words and writes them back. Register 0 is never written.

Parameters:
- SIZE, 16, number of registers in the attached register file (power of 2, >= 2).
- WIDTH, 32, register word width in bits (`WORD_LENGTH`).

Ports:
- clk  in  1  system clock; all state changes on the posedge.
- rst  in  1  asynchronous, active-low reset.
- scanStart  in  1  pulse; starts a pass. Ignored while scanBusy=1.
- scanWrite  in  1  sampled with scanStart; 1 = write back shifted-in words.
- scanAbort  in  1  terminates a pass at the next clock edge.
- scanBusy  out  1  high from the cycle after an accepted scanStart until return to IDLE.
- scanDone  out  1  one-cycle pulse on normal completion.
- portReq  out  1  requests ownership of the register file ports.
- portGnt  in  1  ownership grant from the pipeline.
- rdAddr  out  $clog2(SIZE)  read address to the register file.
- rdData  in  WIDTH  asynchronous read data from the register file.
- wrEnable  out  1  write strobe to the register file.
- wrAddr  out  $clog2(SIZE)  write address.
- wrData  out  WIDTH  write data.
- sEnable  in  1  bit-advance qualifier, synchronous to clk.
- sIn  in  1  serial data in.
- sOut  out  1  serial data out; always equals shiftReg[WIDTH-1].

Behaviour:
- Reset (rst=0, async): state=IDLE, addr=0, shiftReg=0, bitCnt=0, writeBack=0. All outputs 0 (scanBusy, scanDone, portReq, wrEnable, rdAddr, wrAddr, wrData, sOut). A reset mid-pass drops portReq immediately; no partial write is issued.
- States: IDLE, REQ, LOAD, SHIFT, WRITE, DONE.
- IDLE
  - scanStart=1: writeBack<=scanWrite, addr<=0, go to REQ.
- REQ
  - portReq=1; stay until portGnt=1, then go to LOAD.
- portReq=1 in REQ, LOAD, SHIFT and WRITE; 0 in IDLE and DONE.
- Grant loss: in LOAD, SHIFT and WRITE every state advance is qualified by portGnt. With portGnt=0 the FSM holds state, shiftReg and bitCnt, and wrEnable is forced to 0.
- rdAddr=addr in every state.
- LOAD (one cycle)
  - shiftReg<=rdData (read in the same cycle), bitCnt<=0, go to SHIFT.
- SHIFT
  - Each cycle with sEnable=1: shiftReg<={shiftReg[WIDTH-2:0], sIn}, bitCnt<=bitCnt+1.
  - sEnable=0 holds the shift state.
  - The last shift is the one with bitCnt==WIDTH-1. After it, shiftReg holds exactly the WIDTH bits shifted in (first bit in lands in the MSB).
  - Exit after the last shift:
    - writeBack=1 and addr!=0: go to WRITE.
    - otherwise, addr==SIZE-1: go to DONE.
    - otherwise: addr<=addr+1, go to LOAD.
- WRITE (one cycle)
  - wrEnable=1, wrAddr=addr, wrData=shiftReg.
  - Then addr==SIZE-1 goes to DONE; otherwise addr<=addr+1 and go to LOAD.
- DONE
  - scanDone=1 for one cycle, go to IDLE.
- Register 0 is never written. The address wraps only by terminating at SIZE-1; there is no rollover.
- bitCnt width is $clog2(WIDTH)+1 so the counter never wraps.
- scanAbort
  - Highest priority in every non-IDLE state: next state IDLE, portReq=0, no wrEnable that cycle, no scanDone.
  - scanAbort and scanStart together in IDLE: start is ignored.
- Timing: with portGnt and sEnable continuously high, each register costs 1+WIDTH cycles, plus 1 cycle when written back.
- wrAddr and wrData outputs are 0 outside WRITE.

Test Plan:
- SIZE=4, WIDTH=8; regs={0x00,0xA5,0x3C,0xFF}; scanWrite=0; portGnt and sEnable high. Expected: sOut stream 00000000_10100101_00111100_11111111; scanDone exactly 36 cycles after first LOAD; wrEnable never asserted.
- Same setup with scanWrite=1 and sIn fed 0x11,0x22,0x33,0x44. Expected: writes 0x22@1, 0x33@2, 0x44@3, each a one-cycle wrEnable; no write to reg 0; scanDone 39 cycles after first LOAD.
- portGnt held 0 for 5 cycles after scanStart. Expected: portReq=1 and the FSM stays in REQ. portGnt dropped mid-SHIFT for 3 cycles: sOut and bitCnt frozen, shifting resumes without losing a bit.
- sEnable toggled 1/0 every cycle. Expected: sOut bit sequence identical to test 1; duration about doubles for the SHIFT portion.
- scanAbort asserted in WRITE of reg 2. Expected: wrEnable=0 that cycle, next cycle IDLE, portReq=0, scanBusy=0, no scanDone; reg 2 is unchanged.
- rst pulsed low mid-SHIFT. Expected: all outputs 0 immediately. A new scanStart after reset starts again at addr 0.
